eth_rx_frame_writer: RTL and testbench

// Upstream stage of the byte-write / word-read frame buffer (ebr). Takes the MAC RX

---
 rtl/eth_pkg.sv | 16 +
 rtl/sat_counter.sv | 27 ++
 rtl/eth_rx_frame_writer.sv | 145 ++++++++++++++
 tb/tb_eth_rx_frame_writer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet RX definitions: frame-writer states, frame length limits, counter widths.
// Pure definitions; no logic, no latency, no flow control.
package eth_pkg;

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        WRITE,
        DROP
    } rx_wr_state_t;

    localparam int ETH_MIN_LEN = 60;
    localparam int ETH_MAX_LEN = 1518;
    localparam int DROP_CNT_W  = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; value updates one edge after inc/clear.
// No backpressure: increments past all-ones are absorbed silently.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    input  logic         i_clear,
    output logic [W-1:0] o_value
);

    logic [W-1:0] r_value;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_value <= '0;
        end else if (i_clear) begin
            r_value <= '0;
        end else if (i_inc && (r_value != {W{1'b1}})) begin
            r_value <= r_value + 1'b1;
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/eth_rx_frame_writer.sv
// Writes one good MAC RX frame at a time into the byte buffer from address 0; writes appear one edge after the byte.
// No RX backpressure: frames that cannot be held (frame already posted, bad, oversize) are dropped and counted.
module eth_rx_frame_writer
    import eth_pkg::*;
#(
    parameter int SIZE       = 2048,
    parameter int SIZE_WIDTH = $clog2(SIZE),
    parameter int MIN_LEN    = ETH_MIN_LEN,
    parameter int LEN_WIDTH  = SIZE_WIDTH + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    input  logic                  i_rx_last,
    input  logic                  i_rx_err,
    output logic                  o_buf_wr_en,
    output logic [SIZE_WIDTH-1:0] o_buf_wr_addr,
    output logic [7:0]            o_buf_wr_data,
    output logic                  o_frame_valid,
    output logic [LEN_WIDTH-1:0]  o_frame_len,
    input  logic                  i_frame_ack,
    output logic [DROP_CNT_W-1:0] o_drop_cnt
);

    localparam logic [LEN_WIDTH-1:0] L_SIZE = LEN_WIDTH'(SIZE);
    localparam logic [LEN_WIDTH-1:0] L_MIN  = LEN_WIDTH'(MIN_LEN);

    rx_wr_state_t          r_state;
    logic [LEN_WIDTH-1:0]  r_cnt;
    logic                  r_wr_en;
    logic [SIZE_WIDTH-1:0] r_wr_addr;
    logic [7:0]            r_wr_data;
    logic                  r_frame_valid;
    logic [LEN_WIDTH-1:0]  r_frame_len;

    logic                  w_eof;
    logic [LEN_WIDTH-1:0]  w_fin_len;
    logic                  w_bad;
    logic                  w_drop_inc;

    assign w_eof = i_rx_valid && i_rx_last;

    // Length the frame would have if this cycle's byte were its last one.
    always_comb begin
        w_fin_len = r_cnt + 1'b1;
        if (r_state == IDLE) begin
            w_fin_len = LEN_WIDTH'(1);
        end
        w_bad      = i_rx_err || (w_fin_len < L_MIN);
        w_drop_inc = 1'b0;
        case (r_state)
            IDLE:    w_drop_inc = w_eof && (r_frame_valid || w_bad);
            WRITE:   w_drop_inc = w_eof && ((r_cnt == L_SIZE) || w_bad);
            DROP:    w_drop_inc = w_eof;
            default: w_drop_inc = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= SYNC;
            r_cnt         <= '0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_frame_valid <= 1'b0;
            r_frame_len   <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (i_frame_ack) begin
                r_frame_valid <= 1'b0;
            end
            case (r_state)
                SYNC: begin
                    r_wr_addr <= '0;
                    if (!i_rx_valid) begin
                        r_state <= IDLE;
                    end
                end
                IDLE: begin
                    r_wr_addr <= '0;
                    if (i_rx_valid) begin
                        if (!r_frame_valid) begin
                            r_wr_en   <= 1'b1;
                            r_wr_data <= i_rx_data;
                            r_cnt     <= LEN_WIDTH'(1);
                            if (!i_rx_last) begin
                                r_state <= WRITE;
                            end else if (!w_bad) begin
                                r_frame_valid <= 1'b1;
                                r_frame_len   <= w_fin_len;
                            end
                        end else if (!i_rx_last) begin
                            r_state <= DROP;
                        end
                    end
                end
                WRITE: begin
                    if (!i_rx_valid) begin
                        r_wr_addr <= r_cnt[SIZE_WIDTH-1:0];
                    end else if (r_cnt == L_SIZE) begin
                        r_state <= i_rx_last ? IDLE : DROP;
                    end else begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_cnt[SIZE_WIDTH-1:0];
                        r_wr_data <= i_rx_data;
                        r_cnt     <= w_fin_len;
                        if (i_rx_last) begin
                            r_state <= IDLE;
                            if (!w_bad) begin
                                r_frame_valid <= 1'b1;
                                r_frame_len   <= w_fin_len;
                            end
                        end
                    end
                end
                DROP: begin
                    r_wr_addr <= '0;
                    if (w_eof) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= SYNC;
            endcase
        end
    end

    sat_counter #(
        .W(DROP_CNT_W)
    ) u_drop_cnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (w_drop_inc),
        .i_clear (1'b0),
        .o_value (o_drop_cnt)
    );

    assign o_buf_wr_en   = r_wr_en;
    assign o_buf_wr_addr = r_wr_addr;
    assign o_buf_wr_data = r_wr_data;
    assign o_frame_valid = r_frame_valid;
    assign o_frame_len   = r_frame_len;

endmodule

// File: tb/tb_eth_rx_frame_writer.sv
// Drives two writers (SIZE 2048 and SIZE 64) with the same RX stream and checks both against a frame-level model.
module tb_eth_rx_frame_writer;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_last;
    logic       rx_err;
    logic       frame_ack;

    logic        d0_en, d1_en, d0_fv, d1_fv;
    logic [10:0] d0_addr;
    logic [5:0]  d1_addr;
    logic [7:0]  d0_data, d1_data;
    logic [11:0] d0_len;
    logic [6:0]  d1_len;
    logic [15:0] d0_drop, d1_drop;

    logic [31:0] a_en[2], a_addr[2], a_data[2], a_fv[2], a_len[2], a_drop[2];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 0;

    // model of what each DUT must show after the coming edge
    bit   m_sync[2], m_in[2], m_acc[2], m_fv[2];
    int   m_n[2], m_len[2], m_drop[2];
    bit   exp_en[2], exp_gap[2], exp_rst;
    int   exp_addr[2];
    logic [7:0] exp_data[2];

    eth_rx_frame_writer u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .i_rx_last(rx_last), .i_rx_err(rx_err), .o_buf_wr_en(d0_en), .o_buf_wr_addr(d0_addr),
        .o_buf_wr_data(d0_data), .o_frame_valid(d0_fv), .o_frame_len(d0_len),
        .i_frame_ack(frame_ack), .o_drop_cnt(d0_drop)
    );

    eth_rx_frame_writer #(.SIZE(64)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
        .i_rx_last(rx_last), .i_rx_err(rx_err), .o_buf_wr_en(d1_en), .o_buf_wr_addr(d1_addr),
        .o_buf_wr_data(d1_data), .o_frame_valid(d1_fv), .o_frame_len(d1_len),
        .i_frame_ack(frame_ack), .o_drop_cnt(d1_drop)
    );

    assign a_en[0] = 32'(d0_en);     assign a_en[1] = 32'(d1_en);
    assign a_addr[0] = 32'(d0_addr); assign a_addr[1] = 32'(d1_addr);
    assign a_data[0] = 32'(d0_data); assign a_data[1] = 32'(d1_data);
    assign a_fv[0] = 32'(d0_fv);     assign a_fv[1] = 32'(d1_fv);
    assign a_len[0] = 32'(d0_len);   assign a_len[1] = 32'(d1_len);
    assign a_drop[0] = 32'(d0_drop); assign a_drop[1] = 32'(d1_drop);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sz(int k);
        return (k == 0) ? 2048 : 64;
    endfunction

    task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s dut%0d @%0t: got %0d, expected %0d", nm, k, $time, act, expv);
        end
    endtask

    // One clock cycle of stimulus; the model is advanced in frame terms.
    task automatic step(bit rst, bit v, bit l, bit e, bit a, logic [7:0] d);
        bit fv_old;
        @(negedge clk);
        rst_n     = !rst;
        rx_valid  = v;
        rx_last   = l;
        rx_err    = e;
        frame_ack = a;
        rx_data   = d;
        exp_rst   = rst;
        for (int k = 0; k < 2; k++) begin
            exp_en[k]  = 0;
            exp_gap[k] = 0;
            if (rst) begin
                m_sync[k] = 1; m_in[k] = 0; m_fv[k] = 0; m_len[k] = 0; m_drop[k] = 0;
            end else begin
                fv_old = m_fv[k];
                if (a) m_fv[k] = 0;
                if (!v) begin
                    m_sync[k] = 0;
                    if (m_in[k] && m_acc[k] && m_n[k] < sz(k)) begin
                        exp_gap[k]  = 1;
                        exp_addr[k] = m_n[k];
                    end
                end else if (!m_sync[k]) begin
                    if (!m_in[k]) begin
                        m_in[k] = 1; m_acc[k] = !fv_old; m_n[k] = 0;
                    end
                    if (m_acc[k] && m_n[k] < sz(k)) begin
                        exp_en[k] = 1; exp_addr[k] = m_n[k]; exp_data[k] = d;
                    end
                    m_n[k]++;
                    if (l) begin
                        m_in[k] = 0;
                        if (m_acc[k] && !e && m_n[k] >= 60 && m_n[k] <= sz(k)) begin
                            m_fv[k] = 1; m_len[k] = m_n[k];
                        end else if (m_drop[k] < 65535) begin
                            m_drop[k]++;
                        end
                    end
                end
            end
        end
        chk_on = 1;
    endtask

    task automatic idle(int cycles);
        for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0, 8'h00);
    endtask

    task automatic send_frame(int n, bit err, int g1, int g2, int glen, bit rnd, bit ack_first);
        for (int i = 0; i < n; i++) begin
            if (i == g1 || i == g2) begin
                for (int j = 0; j < glen; j++)
                    step(0, 0, rnd ? 1'($urandom_range(0, 1)) : 1'b0, rnd ? 1'($urandom_range(0, 1)) : 1'b0,
                         rnd ? ($urandom_range(0, 5) == 0) : 1'b0, 8'($urandom));
            end
            step(0, 1, i == n - 1,
                 (i == n - 1) ? err : (rnd ? ($urandom_range(0, 7) == 0) : 1'b0),
                 (i == 0 && ack_first) || (rnd && $urandom_range(0, 5) == 0),
                 8'($urandom));
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                chk("wr_en", k, a_en[k], 32'(exp_en[k]));
                if (exp_en[k]) begin
                    chk("wr_addr", k, a_addr[k], exp_addr[k]);
                    chk("wr_data", k, a_data[k], 32'(exp_data[k]));
                end else if (exp_gap[k]) begin
                    chk("gap_addr", k, a_addr[k], exp_addr[k]);
                end else if (exp_rst) begin
                    chk("rst_addr", k, a_addr[k], 0);
                    chk("rst_data", k, a_data[k], 0);
                end
                chk("frame_valid", k, a_fv[k], 32'(m_fv[k]));
                chk("frame_len", k, a_len[k], m_len[k]);
                chk("drop_cnt", k, a_drop[k], m_drop[k]);
            end
        end
    end

    initial begin
        rst_n = 0; rx_data = 0; rx_valid = 0; rx_last = 0; rx_err = 0; frame_ack = 0;
        repeat (3) step(1, 0, 0, 0, 0, 8'h00);
        chk("lit_rst_en", 0, a_en[0], 0);
        chk("lit_rst_addr", 0, a_addr[0], 0);
        chk("lit_rst_data", 0, a_data[0], 0);
        chk("lit_rst_fv", 0, a_fv[0], 0);
        chk("lit_rst_len", 0, a_len[0], 0);
        chk("lit_rst_drop", 0, a_drop[0], 0);
        idle(2);

        // good 64-byte frame, no gaps
        send_frame(64, 0, -1, -1, 0, 0, 0); idle(1);
        chk("lit_64_fv", 0, a_fv[0], 1);
        chk("lit_64_len", 0, a_len[0], 64);
        chk("lit_64_len", 1, a_len[1], 64);
        chk("lit_64_drop", 0, a_drop[0], 0);
        step(0, 0, 0, 0, 1, 8'h00); idle(1);

        // 100 bytes with 3-cycle gaps after bytes 10 and 50
        send_frame(100, 0, 10, 50, 3, 0, 0); idle(1);
        chk("lit_100_len", 0, a_len[0], 100);
        chk("lit_100_drop", 1, a_drop[1], 1);
        step(0, 0, 0, 0, 1, 8'h00); idle(1);

        send_frame(64, 1, -1, -1, 0, 0, 0); idle(1);
        chk("lit_err_fv", 0, a_fv[0], 0);
        chk("lit_err_drop", 0, a_drop[0], 1);
        send_frame(20, 0, -1, -1, 0, 0, 0); idle(1);
        chk("lit_runt_drop", 0, a_drop[0], 2);

        // frame arriving while one is held; ack coincides with its first byte
        send_frame(64, 0, -1, -1, 0, 0, 0); idle(1);
        send_frame(70, 0, -1, -1, 0, 0, 1); idle(1);
        chk("lit_held_drop", 0, a_drop[0], 3);
        chk("lit_held_len", 0, a_len[0], 64);
        chk("lit_held_fv", 0, a_fv[0], 0);
        send_frame(80, 0, -1, -1, 0, 0, 0); idle(1);
        chk("lit_80_len", 0, a_len[0], 80);
        chk("lit_80_drop", 1, a_drop[1], 5);
        step(0, 0, 0, 0, 1, 8'h00); idle(1);

        // oversize on the SIZE=64 writer, then an exactly-full frame
        send_frame(70, 0, -1, -1, 0, 0, 0); idle(1);
        chk("lit_ovr_fv", 1, a_fv[1], 0);
        chk("lit_ovr_drop", 1, a_drop[1], 6);
        send_frame(64, 0, -1, -1, 0, 0, 0); idle(1);
        chk("lit_full_fv", 1, a_fv[1], 1);
        chk("lit_full_len", 1, a_len[1], 64);
        chk("lit_full_drop", 0, a_drop[0], 4);
        step(0, 0, 0, 0, 1, 8'h00); idle(1);

        // SIZE-length and SIZE+1 frames on the 2048-byte writer
        send_frame(2048, 0, -1, -1, 0, 0, 0); idle(1);
        chk("lit_2048_len", 0, a_len[0], 2048);
        step(0, 0, 0, 0, 1, 8'h00); idle(1);
        send_frame(2049, 0, -1, -1, 0, 0, 0); idle(1);
        chk("lit_2049_fv", 0, a_fv[0], 0);
        chk("lit_2049_drop", 0, a_drop[0], 5);

        // reset asserted at byte 30 of 100, released at byte 35
        for (int i = 0; i < 100; i++) step(i >= 30 && i < 35, 1, i == 99, 0, 0, 8'($urandom));
        idle(1);
        chk("lit_rstmid_drop", 0, a_drop[0], 0);
        chk("lit_rstmid_fv", 0, a_fv[0], 0);
        send_frame(60, 0, -1, -1, 0, 0, 0); idle(1);
        chk("lit_60_len", 0, a_len[0], 60);
        chk("lit_60_len", 1, a_len[1], 60);

        // randomized frames, gaps, errors and acks
        for (int f = 0; f < 60; f++) begin
            int n, sel, glen, g1;
            sel = $urandom_range(0, 9);
            case (sel)
                0: n = 1;
                1: n = 59;
                2: n = 60;
                3: n = 61;
                4: n = 63;
                5: n = 64;
                6: n = 65;
                7: n = 20;
                default: n = $urandom_range(60, 100);
            endcase
            g1   = $urandom_range(0, n);
            glen = $urandom_range(0, 3);
            for (int j = 0; j < int'($urandom_range(0, 2)); j++)
                step(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 2) == 0, 8'($urandom));
            send_frame(n, $urandom_range(0, 5) == 0, g1, -1, glen, 1, 0);
        end
        idle(3);
        chk_on = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
